hp48_bus_ctrl: RTL and testbench

// Bus master that sits directly upstream of the memory-mapped devices (hp48_io_ram and peers).

---
 rtl/hp48_bus_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_hp48_bus_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hp48_bus_ctrl.sv
// hp48_bus_ctrl: bus master in front of the memory-mapped HP48 devices.
// Turns one CPU transfer request into the nibble-serial bus command stream
// (LOAD_PC/LOAD_DP, N x PC/DP READ/WRITE, CONFIGURE, RESET) and packs read
// nibbles into one response word.
//
// Every bus_* output and every response output is registered. At each strobe
// edge the block drives the command for the state it is in at that edge, then
// advances the state. Devices sample on the following edge.
//
// Ports
//   strobe, reset       bus clock; asynchronous active-low reset
//   req_*               request channel; accepted when req_valid & req_ready
//   resp_valid/data     one-cycle completion pulse, plus read data
//   err                 sticky error (bus_error or reserved op)
//   bus_command/address/nibble_out  command stream to the devices
//   bus_nibble_in/error             returns from the devices
module hp48_bus_ctrl #(
  parameter int unsigned MAX_NIB = 16,
  parameter int unsigned ADDR_W  = 20
) (
  input  logic                   strobe,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic                   req_ptr,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [3:0]             req_len,
  input  logic [4*MAX_NIB-1:0]   req_data,
  output logic                   resp_valid,
  output logic [4*MAX_NIB-1:0]   resp_data,
  output logic                   err,
  output logic [3:0]             bus_command,
  output logic [ADDR_W-1:0]      bus_address,
  output logic [3:0]             bus_nibble_out,
  input  logic [3:0]             bus_nibble_in,
  input  logic                   bus_error
);

  localparam logic [3:0] BusCmdPcRead    = 4'h2;
  localparam logic [3:0] BusCmdDpRead    = 4'h3;
  localparam logic [3:0] BusCmdPcWrite   = 4'h4;
  localparam logic [3:0] BusCmdDpWrite   = 4'h5;
  localparam logic [3:0] BusCmdLoadPc    = 4'h6;
  localparam logic [3:0] BusCmdLoadDp    = 4'h7;
  localparam logic [3:0] BusCmdConfigure = 4'h8;
  localparam logic [3:0] BusCmdReset     = 4'hF;

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpCfg   = 2'b10;

  localparam logic [2:0] StRstBus = 3'd0;
  localparam logic [2:0] StIdle   = 3'd1;
  localparam logic [2:0] StLoad   = 3'd2;
  localparam logic [2:0] StXfer   = 3'd3;
  localparam logic [2:0] StDrain  = 3'd4;
  localparam logic [2:0] StResp   = 3'd5;
  localparam logic [2:0] StCfg    = 3'd6;

  logic [2:0]           state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic                 ptr_q, ptr_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [3:0]           len_q, len_d;
  logic [4*MAX_NIB-1:0] data_q, data_d;
  logic [3:0]           idx_q, idx_d;
  logic                 drain_q, drain_d;
  logic [ADDR_W-1:0]    pc_shadow_q, pc_shadow_d, dp_shadow_q, dp_shadow_d;
  logic                 pc_known_q, pc_known_d, dp_known_q, dp_known_d;
  // Two-stage read-capture pipeline: a read issued at edge t is captured at t+2.
  logic                 cap1_vld_q, cap1_vld_d, cap2_vld_q, cap2_vld_d;
  logic [3:0]           cap1_idx_q, cap1_idx_d, cap2_idx_q, cap2_idx_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [4*MAX_NIB-1:0] resp_data_q, resp_data_d;
  logic                 err_q, err_d;
  logic [3:0]           cmd_q, cmd_d;
  logic [ADDR_W-1:0]    bus_addr_q, bus_addr_d;
  logic [3:0]           nib_q, nib_d;

  logic                 req_known;
  logic [ADDR_W-1:0]    req_shadow;
  logic [ADDR_W-1:0]    cur_shadow;
  logic [ADDR_W-1:0]    filler_addr;

  always_comb begin
    req_known   = req_ptr ? dp_known_q : pc_known_q;
    req_shadow  = req_ptr ? dp_shadow_q : pc_shadow_q;
    cur_shadow  = ptr_q ? dp_shadow_q : pc_shadow_q;
    filler_addr = dp_known_q ? dp_shadow_q : '0;
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    ptr_d        = ptr_q;
    addr_d       = addr_q;
    len_d        = len_q;
    data_d       = data_q;
    idx_d        = idx_q;
    drain_d      = drain_q;
    pc_shadow_d  = pc_shadow_q;
    dp_shadow_d  = dp_shadow_q;
    pc_known_d   = pc_known_q;
    dp_known_d   = dp_known_q;
    cap1_vld_d   = 1'b0;
    cap1_idx_d   = idx_q;
    cap2_vld_d   = cap1_vld_q;
    cap2_idx_d   = cap1_idx_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    err_d        = err_q | bus_error;
    // Idempotent filler: reloading DP with its known value never changes a device.
    cmd_d        = BusCmdLoadDp;
    bus_addr_d   = filler_addr;
    nib_d        = 4'h0;

    if (cap2_vld_q) begin
      resp_data_d[{cap2_idx_q, 2'b00} +: 4] = bus_nibble_in;
    end

    case (state_q)
      StRstBus: begin
        cmd_d      = BusCmdReset;
        bus_addr_d = '0;
        state_d    = StIdle;
      end
      StIdle: begin
        if (req_valid) begin
          op_d        = req_op;
          ptr_d       = req_ptr;
          addr_d      = req_addr;
          len_d       = req_len;
          data_d      = req_data;
          idx_d       = 4'd0;
          drain_d     = 1'b0;
          resp_data_d = '0;
          if (req_op == OpCfg) begin
            state_d = StCfg;
          end else if (req_op == 2'b11) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else if (req_known && (req_shadow == req_addr)) begin
            state_d = StXfer;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        cmd_d      = ptr_q ? BusCmdLoadDp : BusCmdLoadPc;
        bus_addr_d = addr_q;
        if (ptr_q) begin
          dp_shadow_d = addr_q;
          dp_known_d  = 1'b1;
        end else begin
          pc_shadow_d = addr_q;
          pc_known_d  = 1'b1;
        end
        state_d = StXfer;
      end
      StXfer: begin
        bus_addr_d = cur_shadow;
        if (op_q == OpWrite) begin
          cmd_d = ptr_q ? BusCmdDpWrite : BusCmdPcWrite;
          nib_d = data_q[{idx_q, 2'b00} +: 4];
        end else begin
          cmd_d      = ptr_q ? BusCmdDpRead : BusCmdPcRead;
          cap1_vld_d = 1'b1;
          cap1_idx_d = idx_q;
        end
        // Devices auto-increment their pointer per command; track it.
        if (ptr_q) begin
          dp_shadow_d = dp_shadow_q + ADDR_W'(1);
        end else begin
          pc_shadow_d = pc_shadow_q + ADDR_W'(1);
        end
        if (idx_q == len_q) begin
          state_d = (op_q == OpWrite) ? StResp : StDrain;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      StDrain: begin
        if (drain_q) begin
          state_d = StResp;
        end else begin
          drain_d = 1'b1;
        end
      end
      StCfg: begin
        cmd_d      = BusCmdConfigure;
        bus_addr_d = addr_q;
        state_d    = StResp;
      end
      StResp: begin
        resp_valid_d = 1'b1;
        state_d      = StIdle;
      end
      default: begin
        state_d = StRstBus;
      end
    endcase
  end

  always_ff @(posedge strobe or negedge reset) begin
    if (!reset) begin
      state_q      <= StRstBus;
      op_q         <= 2'b00;
      ptr_q        <= 1'b0;
      addr_q       <= '0;
      len_q        <= 4'd0;
      data_q       <= '0;
      idx_q        <= 4'd0;
      drain_q      <= 1'b0;
      pc_shadow_q  <= '0;
      dp_shadow_q  <= '0;
      pc_known_q   <= 1'b0;
      dp_known_q   <= 1'b0;
      cap1_vld_q   <= 1'b0;
      cap1_idx_q   <= 4'd0;
      cap2_vld_q   <= 1'b0;
      cap2_idx_q   <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
      cmd_q        <= BusCmdLoadDp;
      bus_addr_q   <= '0;
      nib_q        <= 4'h0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      ptr_q        <= ptr_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      data_q       <= data_d;
      idx_q        <= idx_d;
      drain_q      <= drain_d;
      pc_shadow_q  <= pc_shadow_d;
      dp_shadow_q  <= dp_shadow_d;
      pc_known_q   <= pc_known_d;
      dp_known_q   <= dp_known_d;
      cap1_vld_q   <= cap1_vld_d;
      cap1_idx_q   <= cap1_idx_d;
      cap2_vld_q   <= cap2_vld_d;
      cap2_idx_q   <= cap2_idx_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
      cmd_q        <= cmd_d;
      bus_addr_q   <= bus_addr_d;
      nib_q        <= nib_d;
    end
  end

  assign req_ready      = (state_q == StIdle);
  assign resp_valid     = resp_valid_q;
  assign resp_data      = resp_data_q;
  assign err            = err_q;
  assign bus_command    = cmd_q;
  assign bus_address    = bus_addr_q;
  assign bus_nibble_out = nib_q;

endmodule

// File: tb/tb_hp48_bus_ctrl.sv
// Bench for hp48_bus_ctrl: a small behavioural nibble device answers bus
// commands; a table of requests is applied and each response, latency and
// command trace is compared against hand-computed values.
module tb_hp48_bus_ctrl;

  localparam logic [3:0] C_PC_READ  = 4'h2;
  localparam logic [3:0] C_DP_READ  = 4'h3;
  localparam logic [3:0] C_PC_WRITE = 4'h4;
  localparam logic [3:0] C_DP_WRITE = 4'h5;
  localparam logic [3:0] C_LOAD_PC  = 4'h6;
  localparam logic [3:0] C_LOAD_DP  = 4'h7;
  localparam logic [3:0] C_CONFIG   = 4'h8;
  localparam logic [3:0] C_RESET    = 4'hF;

  logic        strobe = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic        req_ptr = 1'b0;
  logic [19:0] req_addr = '0;
  logic [3:0]  req_len = '0;
  logic [63:0] req_data = '0;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        err;
  logic [3:0]  bus_command;
  logic [19:0] bus_address;
  logic [3:0]  bus_nibble_out;
  logic [3:0]  bus_nibble_in;
  logic        bus_error = 1'b0;

  hp48_bus_ctrl dut (
    .strobe         (strobe),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_ptr        (req_ptr),
    .req_addr       (req_addr),
    .req_len        (req_len),
    .req_data       (req_data),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .err            (err),
    .bus_command    (bus_command),
    .bus_address    (bus_address),
    .bus_nibble_out (bus_nibble_out),
    .bus_nibble_in  (bus_nibble_in),
    .bus_error      (bus_error)
  );

  always #5 strobe = ~strobe;

  // Behavioural device: samples the bus on posedge, answers reads one edge later.
  logic [3:0]  mem [4096];
  logic [19:0] dev_pc, dev_dp;

  always @(posedge strobe or negedge reset) begin
    if (!reset) begin
      dev_pc        <= '0;
      dev_dp        <= '0;
      bus_nibble_in <= 4'h0;
      for (int i = 0; i < 4096; i++) mem[i] <= 4'(i) ^ 4'h5;
    end else begin
      case (bus_command)
        C_LOAD_PC: dev_pc <= bus_address;
        C_LOAD_DP: dev_dp <= bus_address;
        C_PC_READ: begin bus_nibble_in <= mem[dev_pc[11:0]]; dev_pc <= dev_pc + 20'd1; end
        C_DP_READ: begin bus_nibble_in <= mem[dev_dp[11:0]]; dev_dp <= dev_dp + 20'd1; end
        C_PC_WRITE: begin mem[dev_pc[11:0]] <= bus_nibble_out; dev_pc <= dev_pc + 20'd1; end
        C_DP_WRITE: begin mem[dev_dp[11:0]] <= bus_nibble_out; dev_dp <= dev_dp + 20'd1; end
        default: ;
      endcase
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic        ptr;
    logic [19:0] addr;
    logic [3:0]  len;
    logic [63:0] data;
    logic        load;
    int          lat;
    logic [63:0] resp;
    logic [19:0] fill;
    logic        err;
  } txn_t;

  function automatic txn_t mk(input logic [1:0] op, input logic ptr, input logic [19:0] addr,
                              input logic [3:0] len, input logic [63:0] data, input logic load,
                              input int lat, input logic [63:0] resp, input logic [19:0] fill,
                              input logic e);
    txn_t t;
    t.op = op; t.ptr = ptr; t.addr = addr; t.len = len; t.data = data; t.load = load;
    t.lat = lat; t.resp = resp; t.fill = fill; t.err = e;
    return t;
  endfunction

  logic [3:0]  tr_cmd  [41];
  logic [19:0] tr_addr [41];
  logic [3:0]  tr_nib  [41];

  // Issue one request at a negedge and check everything it produces.
  task automatic run_txn(input string tag, input txn_t t);
    int lat;
    int ld;
    logic [3:0] xcmd;
    logic [3:0] fcmd;
    logic [63:0] dat;
    lat = 0;
    ld = t.load ? 1 : 0;
    dat = t.data;
    check({tag, " ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_op = t.op; req_ptr = t.ptr; req_addr = t.addr;
    req_len = t.len; req_data = t.data;
    @(negedge strobe);
    req_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge strobe);
      tr_cmd[n] = bus_command; tr_addr[n] = bus_address; tr_nib[n] = bus_nibble_out;
      if (resp_valid) begin
        lat = n;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(t.lat));
    check({tag, " resp_data"}, resp_data, t.resp);
    check({tag, " err"}, 64'(err), 64'(t.err));
    check({tag, " filler cmd"}, 64'(tr_cmd[lat]), 64'(C_LOAD_DP));
    check({tag, " filler addr"}, 64'(tr_addr[lat]), 64'(t.fill));
    if (t.op == 2'b00) xcmd = t.ptr ? C_DP_READ : C_PC_READ;
    else xcmd = t.ptr ? C_DP_WRITE : C_PC_WRITE;
    if (t.op == 2'b10) fcmd = C_CONFIG;
    else if (t.op == 2'b11) fcmd = C_LOAD_DP;
    else if (t.load) fcmd = t.ptr ? C_LOAD_DP : C_LOAD_PC;
    else fcmd = xcmd;
    check({tag, " first cmd"}, 64'(tr_cmd[1]), 64'(fcmd));
    if (t.op == 2'b10 || (t.op[1] == 1'b0 && t.load))
      check({tag, " first addr"}, 64'(tr_addr[1]), 64'(t.addr));
    if (t.op[1] == 1'b0) begin
      for (int i = 0; i <= int'(t.len); i++) begin
        check($sformatf("%s xfer cmd %0d", tag, i), 64'(tr_cmd[1 + ld + i]), 64'(xcmd));
        if (t.op == 2'b01)
          check($sformatf("%s write nib %0d", tag, i), 64'(tr_nib[1 + ld + i]),
                64'(dat[4*i +: 4]));
      end
    end
    @(negedge strobe);
    check({tag, " resp pulse"}, 64'(resp_valid), 64'd0);
    check({tag, " resp hold"}, resp_data, t.resp);
  endtask

  txn_t tbl [9];
  int   seen;

  initial begin
    tbl[0] = mk(2'd2, 1'b1, 20'h00100, 4'd0, 64'h0,    1'b0, 2, 64'h0,    20'h00000, 1'b0);
    tbl[1] = mk(2'd1, 1'b1, 20'h00100, 4'd3, 64'h4321, 1'b1, 6, 64'h0,    20'h00104, 1'b0);
    tbl[2] = mk(2'd0, 1'b1, 20'h00100, 4'd3, 64'h0,    1'b1, 8, 64'h4321, 20'h00104, 1'b0);
    tbl[3] = mk(2'd0, 1'b1, 20'h00104, 4'd0, 64'h0,    1'b0, 4, 64'h1,    20'h00105, 1'b0);
    tbl[4] = mk(2'd0, 1'b0, 20'h00200, 4'd1, 64'h0,    1'b1, 6, 64'h45,   20'h00105, 1'b0);
    tbl[5] = mk(2'd1, 1'b1, 20'hFFFFF, 4'd1, 64'h87,   1'b1, 4, 64'h0,    20'h00001, 1'b0);
    tbl[6] = mk(2'd0, 1'b1, 20'h00001, 4'd0, 64'h0,    1'b0, 4, 64'h4,    20'h00002, 1'b0);
    tbl[7] = mk(2'd0, 1'b1, 20'hFFFFF, 4'd1, 64'h0,    1'b1, 6, 64'h87,   20'h00001, 1'b0);
    tbl[8] = mk(2'd3, 1'b0, 20'h00555, 4'd5, 64'hFFFF, 1'b0, 1, 64'h0,    20'h00001, 1'b1);

    // Reset state and release.
    repeat (2) @(negedge strobe);
    check("rst cmd", 64'(bus_command), 64'(C_LOAD_DP));
    check("rst addr", 64'(bus_address), 64'd0);
    check("rst ready", 64'(req_ready), 64'd0);
    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst resp_data", resp_data, 64'd0);
    check("rst err", 64'(err), 64'd0);
    reset = 1'b1;
    @(negedge strobe);
    check("rel cmd reset", 64'(bus_command), 64'(C_RESET));
    check("rel addr reset", 64'(bus_address), 64'd0);
    @(negedge strobe);
    check("rel filler cmd", 64'(bus_command), 64'(C_LOAD_DP));
    check("rel filler addr", 64'(bus_address), 64'd0);
    check("rel ready", 64'(req_ready), 64'd1);
    check("rel err", 64'(err), 64'd0);

    for (int k = 0; k < 9; k++) run_txn($sformatf("txn%0d", k), tbl[k]);

    // Reset during XFER, with an ignored request held during the transfer.
    req_valid = 1'b1; req_op = 2'd1; req_ptr = 1'b1; req_addr = 20'h00300;
    req_len = 4'd7; req_data = 64'h89ABCDEF;
    @(negedge strobe);
    req_op = 2'd2; req_addr = 20'h00777;
    seen = 0;
    repeat (3) begin
      @(negedge strobe);
      if (bus_command == C_CONFIG) seen++;
    end
    check("abort in xfer", 64'(bus_command), 64'(C_DP_WRITE));
    check("abort no cfg accepted", 64'(seen), 64'd0);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("abort cmd", 64'(bus_command), 64'(C_LOAD_DP));
    check("abort ready", 64'(req_ready), 64'd0);
    check("abort err cleared", 64'(err), 64'd0);
    @(negedge strobe);
    reset = 1'b1;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge strobe);
      if (n == 0) check("abort reset cmd", 64'(bus_command), 64'(C_RESET));
      if (n == 1) check("abort filler addr", 64'(bus_address), 64'd0);
      if (resp_valid) seen++;
    end
    check("abort no resp", 64'(seen), 64'd0);
    // Known flags cleared: DP shadow is 0 but a LOAD_DP must still be issued.
    run_txn("postrst", mk(2'd0, 1'b1, 20'h00000, 4'd0, 64'h0, 1'b1, 5, 64'h5, 20'h00001, 1'b0));

    // bus_error sets the sticky err; transfers still complete.
    bus_error = 1'b1;
    @(negedge strobe);
    bus_error = 1'b0;
    @(negedge strobe);
    check("buserr err set", 64'(err), 64'd1);
    run_txn("buserr cfg", mk(2'd2, 1'b1, 20'h00100, 4'd0, 64'h0, 1'b0, 2, 64'h0, 20'h00001, 1'b1));
    repeat (3) @(negedge strobe);
    check("buserr sticky", 64'(err), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
